// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson code checker.
// Holds the FSM state type and the legal 4-bit code table.
package johnson_pkg;

  localparam int CODE_W = 4;
  localparam int IDX_W  = 3;
  localparam int N_CODE = 8;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Entry i is the code word whose sequence index is i.
  localparam logic [N_CODE-1:0][CODE_W-1:0] LEGAL_CODES = {
    4'b0001,
    4'b0011,
    4'b0111,
    4'b1111,
    4'b1110,
    4'b1100,
    4'b1000,
    4'b0000
  };

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational decoder from a 4-bit Johnson word to {legal, idx}.
// Unlisted words decode as illegal with idx forced to zero.
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              legal,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CODE; i++) begin
      if (code == LEGAL_CODES[i]) begin
        legal = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_code_checker.sv
// Johnson code sequence checker: decode, lock FSM with flywheel,
// error strobes and a saturating error counter, all registered.
module johnson_code_checker
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic [IDX_W-1:0]  idx,
  output logic              idx_valid,
  output logic              locked,
  output logic              illegal_err,
  output logic              seq_err,
  output logic [7:0]        err_cnt
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_e state_q, state_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [3:0] run_q, run_d;
  logic [3:0] miss_q, miss_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic idx_valid_q, idx_valid_d;
  logic locked_q, locked_d;
  logic illegal_err_q, illegal_err_d;
  logic seq_err_q, seq_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic lut_legal;
  logic [IDX_W-1:0] lut_idx;
  logic [IDX_W-1:0] next_exp;
  logic in_seq;
  logic [3:0] run_inc;
  logic [3:0] miss_inc;

  johnson_code_lut u_lut (
    .code  (code),
    .legal (lut_legal),
    .idx   (lut_idx)
  );

  assign next_exp = prev_q + 3'd1;
  assign in_seq   = lut_legal && (lut_idx == next_exp);
  assign run_inc  = run_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    run_d         = run_q;
    miss_d        = miss_q;
    idx_d         = idx_q;
    idx_valid_d   = 1'b0;
    illegal_err_d = 1'b0;
    seq_err_d     = 1'b0;
    err_cnt_d     = err_cnt_q;
    if (code_valid) begin
      if (lut_legal) begin
        idx_d       = lut_idx;
        idx_valid_d = 1'b1;
      end else begin
        illegal_err_d = 1'b1;
      end
      case (state_q)
        HUNT: begin
          if (lut_legal) begin
            prev_d  = lut_idx;
            run_d   = 4'd0;
            state_d = LOCKING;
          end
        end
        LOCKING: begin
          if (!lut_legal) begin
            state_d = HUNT;
          end else if (in_seq) begin
            run_d  = run_inc;
            prev_d = lut_idx;
            if (run_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            run_d  = 4'd0;
            prev_d = lut_idx;
          end
        end
        LOCKED: begin
          if (in_seq) begin
            miss_d = 4'd0;
            prev_d = lut_idx;
          end else begin
            // Flywheel: assume the source advanced even though we missed it.
            seq_err_d = lut_legal;
            prev_d    = next_exp;
            miss_d    = miss_inc;
            if (miss_inc == LOSS_N) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
      if ((illegal_err_d || seq_err_d) && (err_cnt_q != 8'hff)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      run_q         <= '0;
      miss_q        <= '0;
      idx_q         <= '0;
      idx_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      illegal_err_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      miss_q        <= miss_d;
      idx_q         <= idx_d;
      idx_valid_q   <= idx_valid_d;
      locked_q      <= locked_d;
      illegal_err_q <= illegal_err_d;
      seq_err_q     <= seq_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign idx         = idx_q;
  assign idx_valid   = idx_valid_q;
  assign locked      = locked_q;
  assign illegal_err = illegal_err_q;
  assign seq_err     = seq_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/johnson_code_checker.md
JOHNSON_CODE_CHECKER -- requirements
Module: johnson_code_checker

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- LOCK_CNT, 3, consecutive in-sequence codes needed to enter LOCKED (1..15).
- LOSS_CNT, 2, consecutive bad codes in LOCKED needed to drop to HUNT (1..15).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- code_valid, in, 1, code is sampled this cycle.
- code, in, 4, 4-bit Johnson code word (shift-right, inverted-feedback sequence).
- idx, out, 3, decoded sequence index, registered.
- idx_valid, out, 1, one-cycle strobe: idx updated from a legal code.
- locked, out, 1, high while the FSM is in LOCKED.
- illegal_err, out, 1, one-cycle strobe: sampled code not in the legal set.
- seq_err, out, 1, one-cycle strobe: legal code out of sequence while LOCKED.
- err_cnt, out, 8, saturating count of illegal_err plus seq_err strobes.
REQ-003 Reset SHALL be synchronous and active-high on port reset; clock port SHALL be clk.

Function
REQ-004 Legal codes SHALL decode as 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; the other 8 codes SHALL be illegal.
REQ-005 Sequence rule: expected next index SHALL be (prev+1) mod 8; 7->0 is a legal wrap.
REQ-006 Cycles with code_valid=0 SHALL change no state, and all strobes SHALL be 0.
REQ-007 Every output SHALL be registered; response to a code sampled in cycle N SHALL appear in cycle N+1.
REQ-008 A legal sampled code SHALL set idx to its index and pulse idx_valid in every state; an illegal code SHALL hold idx, keep idx_valid=0 and pulse illegal_err.
REQ-009 FSM states SHALL be HUNT, LOCKING, LOCKED.
REQ-010 HUNT: legal code -> prev=idx, run=0, go LOCKING; illegal -> stay.
REQ-011 LOCKING: in-sequence code -> run+1, prev=idx, go LOCKED when run+1==LOCK_CNT; out-of-sequence legal code -> run=0, prev=idx, stay (no seq_err); illegal -> HUNT.
REQ-012 LOCKED: in-sequence code -> miss=0, prev=idx; out-of-sequence legal -> seq_err; illegal -> illegal_err; on either error prev SHALL advance to (prev+1) mod 8 (flywheel) and miss+1; when miss+1==LOSS_CNT go HUNT.
REQ-013 A repeated code (idx==prev) SHALL count as out of sequence.
REQ-014 illegal_err and seq_err SHALL never assert together; illegal takes precedence.
REQ-015 err_cnt SHALL increment by 1 per error strobe and saturate at 255.
REQ-016 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-017 While reset=1 at a clock edge: state=HUNT, prev=0, run=0, miss=0, idx=0, idx_valid=0, locked=0, illegal_err=0, seq_err=0, err_cnt=0.
REQ-018 reset SHALL override code_valid in the same cycle; reset mid-lock SHALL drop locked on the next edge.

Structure
REQ-019 A shared package johnson_pkg SHALL hold the FSM state enum, the 8-entry legal-code table and the code width constant (4).
REQ-020 One combinational sub-module johnson_code_lut SHALL map code to {legal, idx[2:0]}; FSM, counters and output registers SHALL live in johnson_code_checker.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then feed 0000,1000,1100,1110 valid every cycle -> idx 0,1,2,3; locked=1 one cycle after 1110; err_cnt=0.
- Locked at idx 7, feed 0000 -> idx=0, no error (wrap).
- Locked at idx 2, feed 1010 -> illegal_err pulse, idx holds 2, err_cnt=1, locked=1; then 1111 (idx 4, flywheel expected 4) -> no error, miss cleared.
- Locked at idx 3, feed 0011 twice -> seq_err twice, err_cnt=2, locked=0 after second (LOSS_CNT=2).
- Locked, code_valid low for 5 cycles, then next in-sequence code -> no strobes, stays locked.
- Force 300 illegal codes -> err_cnt saturates at 255; assert reset mid-stream -> all outputs 0 next cycle.
